// File: rtl/snap_mem_resp.sv
// rtl/snap_mem_resp.sv - fixed-latency register-file memory responder with per-entry valid bits
//
// Purpose: accepts one read or write request at a time, completes it with a
// one-cycle ack_vld pulse exactly ACK_LAT cycles after accept. Writes commit
// at the end of the response cycle; reads return registered data during it.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_vld / req_rdy   request handshake (ready only while idle)
//   addr                byte address, entry index = addr[ADDR_WIDTH-1:ADDR_LSB]
//   rd_en / wr_en       operation select; both or neither is an illegal op
//   wr_data             write data
//   ack_vld             one-cycle completion pulse
//   rd_data             registered read data, held until the next read completes
//   err                 illegal-op flag, only ever high together with ack_vld
//   entry_vld           valid bit of the entry selected by the live addr input
//   clr_vld             clears all entry valid bits
module snap_mem_resp #(
    parameter int                   MEM_WIDTH  = 36,
    parameter int                   ADDR_WIDTH = 7,
    parameter int                   ADDR_LSB   = 3,
    parameter int                   ACK_LAT    = 2,
    parameter logic [MEM_WIDTH-1:0] RST_VALUE  = {MEM_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [MEM_WIDTH-1:0]  wr_data,
    output logic                  ack_vld,
    output logic [MEM_WIDTH-1:0]  rd_data,
    output logic                  err,
    output logic                  entry_vld,
    input  logic                  clr_vld
);

    localparam int IDX_W     = ADDR_WIDTH - ADDR_LSB;
    localparam int ENTRY_CNT = 2 ** IDX_W;
    // WAIT spends CNT_INIT+1 cycles, so accept->RESP totals ACK_LAT cycles.
    localparam logic [3:0] CNT_INIT = (ACK_LAT > 1) ? 4'(ACK_LAT - 2) : 4'd0;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WAIT = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   op_rd_q, op_rd_d;
    logic                   op_wr_q, op_wr_d;
    logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MEM_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [MEM_WIDTH-1:0]   mem_q [ENTRY_CNT];
    logic [MEM_WIDTH-1:0]   mem_d [ENTRY_CNT];
    logic [ENTRY_CNT-1:0]   valid_q, valid_d;

    logic             accept;
    logic [IDX_W-1:0] addr_idx;

    assign accept   = req_vld && (state_q == IDLE);
    assign addr_idx = addr[ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        op_rd_d   = op_rd_q;
        op_wr_d   = op_wr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        mem_d     = mem_q;
        valid_d   = clr_vld ? '0 : valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = addr_idx;
                    op_rd_d = rd_en && !wr_en;
                    op_wr_d = wr_en && !rd_en;
                    wdata_d = wr_data;
                    if (ACK_LAT == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read data is loaded on the edge entering RESP; the _d copies hold
        // the captured request even when ACK_LAT=1 skips WAIT.
        if (state_d == RESP && op_rd_d) begin
            rd_data_d = mem_q[idx_d];
        end

        // Write commits on the edge leaving RESP; its valid bit wins over clr_vld.
        if (state_q == RESP && op_wr_q) begin
            mem_d[idx_q]   = wdata_q;
            valid_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            op_rd_q   <= 1'b0;
            op_wr_q   <= 1'b0;
            wdata_q   <= '0;
            rd_data_q <= RST_VALUE;
            valid_q   <= '0;
            for (int i = 0; i < ENTRY_CNT; i++) begin
                mem_q[i] <= RST_VALUE;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            op_rd_q   <= op_rd_d;
            op_wr_q   <= op_wr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            valid_q   <= valid_d;
            mem_q     <= mem_d;
        end
    end

    assign req_rdy   = (state_q == IDLE);
    assign ack_vld   = (state_q == RESP);
    assign err       = (state_q == RESP) && !op_rd_q && !op_wr_q;
    assign rd_data   = rd_data_q;
    assign entry_vld = valid_q[addr_idx];

endmodule

// File: tb/tb_snap_mem_resp.sv
// tb/tb_snap_mem_resp.sv - directed self-checking bench for snap_mem_resp at ACK_LAT 2, 1 and 15
module tb_snap_mem_resp;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [35:0] wr_data;
    logic        clr_vld;

    logic        req_vld   [NI];
    logic        req_rdy   [NI];
    logic        ack_vld   [NI];
    logic [35:0] rd_data   [NI];
    logic        err       [NI];
    logic        entry_vld [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // instance 0: ACK_LAT=2, instance 1: ACK_LAT=1, instance 2: ACK_LAT=15
    for (genvar g = 0; g < NI; g++) begin : g_dut
        snap_mem_resp #(
            .ACK_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_vld   (req_vld[g]),
            .req_rdy   (req_rdy[g]),
            .addr      (addr),
            .rd_en     (rd_en),
            .wr_en     (wr_en),
            .wr_data   (wr_data),
            .ack_vld   (ack_vld[g]),
            .rd_data   (rd_data[g]),
            .err       (err[g]),
            .entry_vld (entry_vld[g]),
            .clr_vld   (clr_vld)
        );
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 15);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int s, input logic [6:0] a, input logic rd, input logic wr,
                       input logic [35:0] wd, input logic exp_err, input logic chk_rd,
                       input logic [35:0] exp_rd, input logic clr_at_resp);
        int  n;
        int  rdy_lo;
        bit  got;
        bit  bad_err;
        @(negedge clk);
        n = 0;
        while (!req_rdy[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("i%0d rdy_before", s), 64'(req_rdy[s]), 64'd1);
        addr = a; rd_en = rd; wr_en = wr; wr_data = wd; req_vld[s] = 1'b1;
        @(posedge clk);
        #1;
        // scramble the request inputs so any late sampling shows up
        req_vld[s] = 1'b0; addr = ~a; rd_en = ~rd; wr_data = ~wd;
        got = 0; rdy_lo = 0; bad_err = 0; n = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (!req_rdy[s]) rdy_lo++;
            if (ack_vld[s]) begin
                got = 1;
                n = i;
            end else if (err[s]) begin
                bad_err = 1;
            end
        end
        check($sformatf("i%0d ack_seen", s), 64'(got), 64'd1);
        check($sformatf("i%0d err_unqualified", s), 64'(bad_err), 64'd0);
        if (got) begin
            check($sformatf("i%0d ack_lat", s), 64'(n), 64'(lat_of(s)));
            check($sformatf("i%0d rdy_low_cycles", s), 64'(rdy_lo), 64'(lat_of(s)));
            check($sformatf("i%0d err", s), 64'(err[s]), 64'(exp_err));
            if (chk_rd) check($sformatf("i%0d rd_data a=%0h", s, a), 64'(rd_data[s]), 64'(exp_rd));
        end
        if (clr_at_resp) begin
            clr_vld = 1'b1;
            @(posedge clk);
            #1;
            clr_vld = 1'b0;
        end
    endtask

    task automatic probe_vld(input int s, input logic [6:0] a, input logic exp);
        @(negedge clk);
        addr = a;
        #1;
        check($sformatf("i%0d entry_vld a=%0h", s, a), 64'(entry_vld[s]), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; rd_en = 0; wr_en = 0; wr_data = '0; clr_vld = 0;
        for (int i = 0; i < NI; i++) req_vld[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < NI; s++) begin
            check($sformatf("i%0d rst req_rdy", s), 64'(req_rdy[s]), 64'd1);
            check($sformatf("i%0d rst ack_vld", s), 64'(ack_vld[s]), 64'd0);
            check($sformatf("i%0d rst err", s), 64'(err[s]), 64'd0);
            check($sformatf("i%0d rst rd_data", s), 64'(rd_data[s]), 64'd0);
            check($sformatf("i%0d rst entry_vld", s), 64'(entry_vld[s]), 64'd0);
        end

        // write 0x08, read back, hold, read unwritten 0x10
        txn(0, 7'h08, 0, 1, 36'h9_DEADBEEF, 0, 0, '0, 0);
        probe_vld(0, 7'h08, 1'b1);
        txn(0, 7'h08, 1, 0, 36'h0, 0, 1, 36'h9_DEADBEEF, 0);
        @(negedge clk);
        check("rd_data_hold_idle", 64'(rd_data[0]), 64'h9_DEADBEEF);
        txn(0, 7'h10, 1, 0, 36'h0, 0, 1, 36'h0_00000000, 0);
        probe_vld(0, 7'h10, 1'b0);

        // illegal ops: both and neither; storage and rd_data untouched
        txn(0, 7'h08, 1, 1, 36'h0, 1, 1, 36'h0_00000000, 0);
        txn(0, 7'h08, 1, 0, 36'h0, 0, 1, 36'h9_DEADBEEF, 0);
        txn(0, 7'h10, 0, 0, 36'h5_55555555, 1, 1, 36'h9_DEADBEEF, 0);
        probe_vld(0, 7'h10, 1'b0);

        // clr_vld coinciding with the write commit of 0x18
        txn(0, 7'h18, 0, 1, 36'h1_23456789, 0, 0, '0, 1);
        probe_vld(0, 7'h18, 1'b1);
        probe_vld(0, 7'h08, 1'b0);
        txn(0, 7'h08, 1, 0, 36'h0, 0, 1, 36'h9_DEADBEEF, 0);
        txn(0, 7'h18, 1, 0, 36'h0, 0, 1, 36'h1_23456789, 0);

        // reset during WAIT of a write to 0x20
        begin
            bit saw_ack;
            @(negedge clk);
            addr = 7'h20; rd_en = 0; wr_en = 1; wr_data = 36'hF_0F0F0F0F; req_vld[0] = 1'b1;
            @(posedge clk);
            #1 req_vld[0] = 1'b0; rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            saw_ack = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (ack_vld[0]) saw_ack = 1;
            end
            check("rst_abort no_ack", 64'(saw_ack), 64'd0);
            check("rst_abort req_rdy", 64'(req_rdy[0]), 64'd1);
            probe_vld(0, 7'h20, 1'b0);
            txn(0, 7'h20, 1, 0, 36'h0, 0, 1, 36'h0, 0);
            txn(0, 7'h08, 1, 0, 36'h0, 0, 1, 36'h0, 0);
        end

        // ACK_LAT=1 and ACK_LAT=15: sweep all 16 entries
        for (int s = 1; s < NI; s++) begin
            for (int i = 0; i < 16; i++)
                txn(s, 7'(i * 8), 0, 1, {4'(i), 32'hA5A5_0000 | 32'(i * 16'h0101)}, 0, 0, '0, 0);
            for (int i = 0; i < 16; i++)
                txn(s, 7'(i * 8 + 3), 1, 0, 36'h0, 0, 1, {4'(i), 32'hA5A5_0000 | 32'(i * 16'h0101)}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snap_mem_resp.md
SNAP_MEM_RESP -- requirements
Module: snap_mem_resp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MEM_WIDTH, 36, entry data width.
- ADDR_WIDTH, 7, byte address width.
- ADDR_LSB, 3, low address bits ignored for entry index; ENTRY_CNT = 2**(ADDR_WIDTH-ADDR_LSB) = 16.
- ACK_LAT, 2, cycles from request accept to ack_vld; legal range 1..15.
- RST_VALUE, {MEM_WIDTH{1'b0}}, storage reset value.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low: clk sampled on rising edge, rst_n low on a rising edge resets.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- addr  in  ADDR_WIDTH  byte address; index = addr[ADDR_WIDTH-1:ADDR_LSB].
- rd_en  in  1  read request.
- wr_en  in  1  write request.
- wr_data  in  MEM_WIDTH  write data.
- ack_vld  out  1  one-cycle completion pulse.
- rd_data  out  MEM_WIDTH  read data, registered.
- err  out  1  illegal-op flag, qualified by ack_vld.
- entry_vld  out  1  valid bit of entry indexed by current addr (combinational).
- clr_vld  in  1  clear all entry valid bits.

Function
REQ-004 Accept SHALL occur on a cycle with req_vld & req_rdy; addr, rd_en, wr_en and wr_data SHALL be captured then.
REQ-005 FSM states SHALL be IDLE, WAIT, RESP, one-hot; req_rdy = IDLE only.
REQ-006 IDLE: accept with ACK_LAT=1 -> RESP; accept with ACK_LAT>1 -> WAIT, counter loaded with ACK_LAT-2; otherwise stay IDLE.
REQ-007 WAIT: counter==0 -> RESP; else decrement, stay WAIT.
REQ-008 RESP: ack_vld=1 for exactly this cycle, then -> IDLE unconditionally; ack_vld SHALL be asserted exactly ACK_LAT cycles after the accept edge.
REQ-009 Write (wr_en=1, rd_en=0): storage[index] <= captured wr_data and valid[index] <= 1 at the end of the RESP cycle; rd_data unchanged; err=0.
REQ-010 Read (rd_en=1, wr_en=0): rd_data SHALL equal storage[index] during the RESP cycle and hold it until the next read's RESP; err=0.
REQ-011 Both or neither of rd_en/wr_en at accept: no storage or rd_data change; ack_vld issued normally with err=1.
REQ-012 err SHALL be 0 whenever ack_vld=0.
REQ-013 Back-to-back: new accept is possible the cycle after RESP; maximum throughput is one transaction per ACK_LAT+1 cycles.
REQ-014 Changes on addr/rd_en/wr_en/wr_data after accept SHALL NOT affect the in-flight transaction.
REQ-015 clr_vld SHALL clear all valid bits at the next edge in any state; if it coincides with a RESP write, that entry's valid bit SHALL end at 1, all others at 0.
REQ-016 Storage data SHALL NOT be altered by clr_vld.

Reset
REQ-017 On reset: state IDLE, counter 0, req_rdy=1 after the reset edge, ack_vld=0, err=0, rd_data=RST_VALUE, all storage=RST_VALUE, all valid bits 0.
REQ-018 Reset during WAIT or RESP SHALL abort the transaction: no ack_vld, no storage write.

Verification
REQ-019 ACK_LAT=2: write addr=0x08, wr_data=0x9_DEADBEEF -> req_rdy low for 2 cycles, ack_vld at accept+2, err=0; entry_vld=1 for addr 0x08.
REQ-020 Read addr=0x08 after REQ-019 -> ack_vld at accept+2, rd_data=0x9_DEADBEEF, held through an idle cycle; read addr=0x10 returns 0x0_00000000 with entry_vld=0.
REQ-021 rd_en=wr_en=1 at addr=0x08 with wr_data=0 -> ack_vld with err=1; a subsequent read still returns 0x9_DEADBEEF.
REQ-022 clr_vld pulsed in the RESP cycle of a write to addr=0x18 -> entry_vld=1 for 0x18, 0 for 0x08; read of 0x08 still returns 0x9_DEADBEEF.
REQ-023 rst_n low during WAIT of a write to addr=0x20 -> no ack_vld; after reset, read of 0x20 returns 0 and req_rdy=1.
REQ-024 ACK_LAT=1 and ACK_LAT=15 builds: back-to-back writes then reads across all 16 entries -> each ack exactly ACK_LAT after accept, data matches.
